// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) master for the boot/XIP flash.
// Keeps CS low between strictly sequential word reads.
module spi_flash_reader #(
    parameter int SCK_HALF       = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        flash_CS,
    output logic        sck_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DESEL
    } state_t;

    localparam logic [15:0] PH_LAST  = 16'(2 * SCK_HALF - 1);
    localparam logic [15:0] PH_HIGH  = 16'(SCK_HALF);
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);
    localparam logic [15:0] DES_LAST = 16'(CS_HIGH_CYCLES - 2);
    // IDLE supplies the last CS-high cycle, so DESELECT covers the rest
    localparam state_t CS_OFF = (CS_HIGH_CYCLES > 1) ? S_DESEL : S_IDLE;

    state_t      state_q, state_d;
    logic [15:0] ph_q, ph_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [21:0] word_q, word_d;
    logic [21:0] last_q, last_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;

    logic        cell_end;
    logic        shifting_d;
    logic [31:0] rx_nx;

    // next-state, shift engine and registered-output computation
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        bcnt_d   = bcnt_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        last_d   = last_q;
        tx_d     = tx_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        mosi_d   = mosi_q;
        cell_end = (ph_q == PH_LAST);
        rx_nx    = rx_q;
        if (state_q == S_DATA && ph_q == PH_HIGH)
            rx_nx = {rx_q[30:0], miso_i};
        rx_d     = rx_nx;

        if (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA)
            ph_d = cell_end ? 16'd0 : ph_q + 16'd1;

        unique case (state_q)
            S_IDLE: begin
                if (req_i && !ack_q) begin
                    word_d  = addr_i[23:2];
                    tx_d    = {8'h03, addr_i[23:2], 2'b00};
                    mosi_d  = tx_d[31];
                    ph_d    = 16'd0;
                    bcnt_d  = 5'd0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (cell_end) begin
                    tx_d   = {tx_q[30:0], 1'b0};
                    mosi_d = tx_q[30];
                    if (bcnt_q == 5'd7) begin
                        bcnt_d  = 5'd0;
                        state_d = S_ADDR;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            S_ADDR: begin
                if (cell_end) begin
                    tx_d   = {tx_q[30:0], 1'b0};
                    mosi_d = tx_q[30];
                    if (bcnt_q == 5'd23) begin
                        bcnt_d  = 5'd0;
                        state_d = S_DATA;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (cell_end) begin
                    if (bcnt_q == 5'd31) begin
                        bcnt_d  = 5'd0;
                        cnt_d   = 16'd0;
                        ack_d   = 1'b1;
                        data_d  = {rx_nx[7:0], rx_nx[15:8],
                                   rx_nx[23:16], rx_nx[31:24]};
                        last_d  = word_q + 22'd1;
                        state_d = S_HOLD;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                if (req_i && !ack_q) begin
                    if (addr_i[23:2] == last_q) begin
                        word_d  = last_q;
                        ph_d    = 16'd0;
                        bcnt_d  = 5'd0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = CS_OFF;
                    end
                end else if (cnt_q == HOLD_LIM) begin
                    cnt_d   = 16'd0;
                    state_d = CS_OFF;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DESEL: begin
                if (cnt_q == DES_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        shifting_d = (state_d == S_CMD) || (state_d == S_ADDR)
                  || (state_d == S_DATA);
        if (state_d != S_CMD && state_d != S_ADDR)
            mosi_d = 1'b0;
        cs_d   = !(shifting_d || state_d == S_HOLD);
        sck_d  = shifting_d && (ph_d >= PH_HIGH);
        busy_d = (state_d != S_IDLE) && (state_d != S_HOLD);
    end

    // state and registered outputs, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ph_q    <= 16'd0;
            bcnt_q  <= 5'd0;
            cnt_q   <= 16'd0;
            word_q  <= 22'd0;
            last_q  <= 22'd0;
            tx_q    <= 32'd0;
            rx_q    <= 32'd0;
            data_q  <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign data_o   = data_q;
    assign ack_o    = ack_q;
    assign busy_o   = busy_q;
    assign flash_CS = cs_q;
    assign sck_o    = sck_q;
    assign mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural
// READ-only flash model and a HOLD_CYCLES=0 / SCK_HALF=1 build.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [23:0] addr_i = 24'd0;
    logic [31:0] data_o;
    logic        ack_o, busy_o, flash_CS, sck_o, mosi_o;
    logic        miso_i = 1'b0;

    logic        req0 = 1'b0;
    logic [23:0] addr0 = 24'd0;
    logic [31:0] data0;
    logic        ack0, busy0, cs0, sck0, mosi0;
    logic        miso0 = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sck_edges = 0;
    int cs_rises = 0;
    int ncmd = 0;
    int fbits = 0;
    int hi_run = 0;
    int last_hi = 0;
    logic [31:0] fcmd = 32'd0;
    logic [7:0]  mem [256];

    spi_flash_reader dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
        .data_o(data_o), .ack_o(ack_o), .busy_o(busy_o),
        .flash_CS(flash_CS), .sck_o(sck_o), .mosi_o(mosi_o),
        .miso_i(miso_i)
    );

    spi_flash_reader #(.SCK_HALF(1), .HOLD_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req0), .addr_i(addr0),
        .data_o(data0), .ack_o(ack0), .busy_o(busy0),
        .flash_CS(cs0), .sck_o(sck0), .mosi_o(mosi0),
        .miso_i(miso0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // CS-high run length, sampled on the clock
    always @(posedge clk) begin
        if (flash_CS) hi_run++;
        else if (hi_run != 0) begin
            last_hi = hi_run;
            hi_run = 0;
        end
    end

    always @(posedge flash_CS) begin
        cs_rises++;
        fbits = 0;
        miso_i = 1'b0;
    end

    // flash model: capture command/address, stream bytes from addr
    always @(posedge sck_o) begin
        sck_edges++;
        if (fbits < 32) fcmd = {fcmd[30:0], mosi_o};
        fbits++;
        if (fbits == 32) ncmd++;
    end

    always @(negedge sck_o) begin
        if (fbits >= 32) begin
            automatic int n = fbits - 32;
            automatic logic [7:0] a = fcmd[7:0] + 8'(n / 8);
            automatic logic [7:0] b = mem[a];
            miso_i = b[7 - (n % 8)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [23:0] a, output int lat);
        int t0;
        sck_edges = 0;
        addr_i = a;
        req_i = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (ack_o) begin
                lat = cyc - t0;
                break;
            end
        end
        req_i = 1'b0;
    endtask

    // cycles from now (an ack cycle) until flash_CS reads high
    task automatic cs_rise_delay(output int d);
        int t0;
        t0 = cyc;
        d = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (flash_CS) begin
                d = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        int lat, d, c0, r0, t0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'hDE; mem[8'h01] = 8'hAD;
        mem[8'h02] = 8'hBE; mem[8'h03] = 8'hEF;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22;
        mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        mem[8'h14] = 8'h55; mem[8'h15] = 8'h66;
        mem[8'h16] = 8'h77; mem[8'h17] = 8'h88;
        mem[8'h40] = 8'hA1; mem[8'h41] = 8'hB2;
        mem[8'h42] = 8'hC3; mem[8'h43] = 8'hD4;
        mem[8'hFC] = 8'h01; mem[8'hFD] = 8'h02;
        mem[8'hFE] = 8'h03; mem[8'hFF] = 8'h04;

        repeat (3) step();
        chk("rst_cs", 32'(flash_CS), 32'd1);
        chk("rst_sck", 32'(sck_o), 32'd0);
        chk("rst_mosi", 32'(mosi_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst_i = 1'b0;
        repeat (8) step();

        // single read
        do_read(24'h000010, lat);
        chk("single_lat", 32'(lat), 32'd257);
        chk("single_data", data_o, 32'h44332211);
        chk("single_cmd", fcmd, 32'h03000010);
        chk("single_edges", 32'(sck_edges), 32'd64);
        step();
        chk("ack_pulse", 32'(ack_o), 32'd0);
        chk("hold_cs", 32'(flash_CS), 32'd0);

        // sequential read inside HOLD
        c0 = ncmd;
        r0 = cs_rises;
        do_read(24'h000014, lat);
        chk("seq_lat", 32'(lat), 32'd129);
        chk("seq_data", data_o, 32'h88776655);
        chk("seq_edges", 32'(sck_edges), 32'd32);
        chk("seq_nocmd", 32'(ncmd - c0), 32'd0);
        chk("seq_cs_low", 32'(cs_rises - r0), 32'd0);

        // non-sequential request from HOLD
        step();
        do_read(24'h000040, lat);
        chk("nseq_cs_hi", 32'(last_hi), 32'd4);
        chk("nseq_cmd", fcmd, 32'h03000040);
        chk("nseq_data", data_o, 32'hD4C3B2A1);
        chk("nseq_edges", 32'(sck_edges), 32'd64);

        // no follow-up: HOLD timeout
        cs_rise_delay(d);
        chk("hold_timeout", 32'(d), 32'd17);
        repeat (10) step();

        // wrap 0xFFFFFC -> 0x000000, low addr bits ignored
        do_read(24'hFFFFFC, lat);
        chk("wrap1_data", data_o, 32'h04030201);
        chk("wrap1_cmd", fcmd, 32'h03FFFFFC);
        c0 = ncmd;
        step();
        do_read(24'h000003, lat);
        chk("wrap2_lat", 32'(lat), 32'd129);
        chk("wrap2_edges", 32'(sck_edges), 32'd32);
        chk("wrap2_nocmd", 32'(ncmd - c0), 32'd0);
        chk("wrap2_data", data_o, 32'hEFBEADDE);
        cs_rise_delay(d);
        chk("wrap_timeout", 32'(d), 32'd17);
        repeat (10) step();

        // reset during ADDR phase
        addr_i = 24'h000040;
        req_i = 1'b1;
        repeat (60) step();
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_cs", 32'(flash_CS), 32'd0);
        rst_i = 1'b1;
        req_i = 1'b0;
        step();
        chk("mrst_cs", 32'(flash_CS), 32'd1);
        chk("mrst_sck", 32'(sck_o), 32'd0);
        chk("mrst_ack", 32'(ack_o), 32'd0);
        chk("mrst_data", data_o, 32'd0);
        step();
        step();
        rst_i = 1'b0;
        repeat (6) step();
        do_read(24'h000000, lat);
        chk("post_rst_lat", 32'(lat), 32'd257);
        chk("post_rst_data", data_o, 32'hEFBEADDE);
        chk("post_rst_cmd", fcmd, 32'h03000000);

        // HOLD_CYCLES=0, SCK_HALF=1 build
        addr0 = 24'h000100;
        req0 = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (ack0) begin
                lat = cyc - t0;
                break;
            end
        end
        req0 = 1'b0;
        chk("h0_lat", 32'(lat), 32'd129);
        chk("h0_data", data0, 32'hFFFFFFFF);
        chk("h0_cs_ack", 32'(cs0), 32'd0);
        step();
        chk("h0_cs_rise", 32'(cs0), 32'd1);
        chk("h0_ack_drop", 32'(ack0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
